// File: rtl/grid_pkg.sv
// Shared types and constants for the grid copy/fill engine.
// The LFSR constants are only consumed when GRID_COPIER_LFSR_EN is defined.
package grid_pkg;

   typedef enum logic [1:0] {
      MODE_COPY   = 2'd0,
      MODE_FILL   = 2'd1,
      MODE_CLEAR  = 2'd2,
      MODE_RANDOM = 2'd3
   } mode_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam logic [15:0] LFSR_MASK         = 16'hB400;
   localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

   // Right-shifting Galois step: the bit shifted out selects the tap mask.
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return s[0] ? ({1'b0, s[15:1]} ^ LFSR_MASK) : {1'b0, s[15:1]};
   endfunction

endpackage

// File: rtl/grid_lfsr.sv
// Seedable 16-bit Galois LFSR; load has priority over step, seed 0 maps to the default seed.
module grid_lfsr
   import grid_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_load,
   input  logic [15:0] i_seed,
   input  logic        i_step,
   output logic [15:0] o_state
);

   logic [15:0] r_state;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= LFSR_DEFAULT_SEED;
      end else if (i_load) begin
         r_state <= (i_seed == 16'd0) ? LFSR_DEFAULT_SEED : i_seed;
      end else if (i_step) begin
         r_state <= lfsr_next(r_state);
      end
   end

   assign o_state = r_state;

endmodule

// File: rtl/grid_copier.sv
// Streaming grid copy/fill engine: one source read issued per cycle, writes fanned out to masked destinations.
// Define GRID_COPIER_LFSR_EN to build the RANDOM-mode LFSR; otherwise mode 3 behaves as CLEAR.
module grid_copier
   import grid_pkg::*;
#(
   parameter int P_PARAM_M    = 5,
   parameter int P_PARAM_N    = 5,
   parameter int WIDTH        = 12,
   parameter int CELL_BITS    = 1,
   parameter int NUM_DST      = 4,
   parameter int READ_LATENCY = 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_start,
   input  logic [1:0]           i_mode,
   input  logic [NUM_DST-1:0]   i_dst_mask,
   input  logic [CELL_BITS-1:0] i_fill_val,
   input  logic [15:0]          i_seed,
   output logic                 o_read_en,
   output logic [2*WIDTH-1:0]   o_read_addr,
   input  logic [CELL_BITS-1:0] i_read_val,
   output logic [NUM_DST-1:0]   o_write_en,
   output logic [2*WIDTH-1:0]   o_write_addr,
   output logic [CELL_BITS-1:0] o_write_val,
   output logic                 o_busy,
   output logic                 o_finish,
   output logic [1:0]           o_dbg_state
);

   localparam int NCELLS = P_PARAM_M * P_PARAM_N;
   localparam int AW     = 2 * WIDTH;
   localparam int DCW    = $clog2(READ_LATENCY + 2);

   state_t               r_state;
   state_t               w_next;
   mode_t                r_mode;
   logic [NUM_DST-1:0]   r_mask;
   logic [CELL_BITS-1:0] r_fill;
   logic [AW-1:0]        r_addr;
   logic [DCW-1:0]       r_drain_cnt;
   logic                 r_finish;

   logic [READ_LATENCY-1:0] r_pipe_vld;
   logic [AW-1:0]           r_pipe_addr [READ_LATENCY];

   logic [NUM_DST-1:0]   r_wen;
   logic [AW-1:0]        r_waddr;
   logic [CELL_BITS-1:0] r_wval;

   logic                 w_accept;
   logic                 w_last_addr;
   logic                 w_drain_done;
   logic                 w_vld_out;
   logic [AW-1:0]        w_addr_out;
   logic [CELL_BITS-1:0] w_cell;

   assign w_accept     = (r_state == ST_IDLE) && i_start;
   assign w_last_addr  = (r_addr == AW'(NCELLS - 1));
   assign w_drain_done = (r_drain_cnt == DCW'(READ_LATENCY));
   assign w_vld_out    = r_pipe_vld[READ_LATENCY-1];
   assign w_addr_out   = r_pipe_addr[READ_LATENCY-1];

`ifdef GRID_COPIER_LFSR_EN
   logic [15:0] w_lfsr;

   grid_lfsr u_lfsr (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_load  (w_accept),
      .i_seed  (i_seed),
      .i_step  (w_vld_out && (r_mode == MODE_RANDOM)),
      .o_state (w_lfsr)
   );
`else
   logic w_unused_seed;
   assign w_unused_seed = ^i_seed;
`endif

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (i_start)      w_next = ST_ISSUE;
         ST_ISSUE: if (w_last_addr)  w_next = ST_DRAIN;
         ST_DRAIN: if (w_drain_done) w_next = ST_IDLE;
         default:                    w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_cell = '0;
      case (r_mode)
         MODE_COPY:   w_cell = i_read_val;
         MODE_FILL:   w_cell = r_fill;
         MODE_CLEAR:  w_cell = '0;
`ifdef GRID_COPIER_LFSR_EN
         MODE_RANDOM: w_cell = w_lfsr[CELL_BITS-1:0];
`else
         MODE_RANDOM: w_cell = '0;
`endif
         default:     w_cell = '0;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= ST_IDLE;
         r_mode      <= MODE_COPY;
         r_mask      <= '0;
         r_fill      <= '0;
         r_addr      <= '0;
         r_drain_cnt <= '0;
         r_finish    <= 1'b0;
         r_pipe_vld  <= '0;
         for (int i = 0; i < READ_LATENCY; i++) r_pipe_addr[i] <= '0;
         r_wen       <= '0;
         r_waddr     <= '0;
         r_wval      <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_mode   <= mode_t'(i_mode);
            r_mask   <= i_dst_mask;
            r_fill   <= i_fill_val;
            r_addr   <= '0;
            r_finish <= 1'b0;
         end
         if (r_state == ST_ISSUE) begin
            r_addr      <= w_last_addr ? '0 : r_addr + AW'(1);
            r_drain_cnt <= '0;
         end
         if (r_state == ST_DRAIN) begin
            r_drain_cnt <= r_drain_cnt + DCW'(1);
            if (w_drain_done) r_finish <= 1'b1;
         end

         // Delay line aligns each issued address with its returning read data.
         r_pipe_vld[0]  <= (r_state == ST_ISSUE);
         r_pipe_addr[0] <= r_addr;
         for (int i = 1; i < READ_LATENCY; i++) begin
            r_pipe_vld[i]  <= r_pipe_vld[i-1];
            r_pipe_addr[i] <= r_pipe_addr[i-1];
         end

         r_wen <= w_vld_out ? r_mask : '0;
         if (w_vld_out) begin
            r_waddr <= w_addr_out;
            r_wval  <= w_cell;
         end
      end
   end

   assign o_read_en    = (r_state == ST_ISSUE);
   assign o_read_addr  = r_addr;
   assign o_write_en   = r_wen;
   assign o_write_addr = r_waddr;
   assign o_write_val  = r_wval;
   assign o_busy       = (r_state != ST_IDLE);
   assign o_finish     = r_finish;
   assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_grid_copier.sv
// Directed bench for grid_copier: two instances (read latency 1 and 3) share stimulus, each with its own source RAM model.
module tb_grid_copier;

   localparam int NC = 25;
   localparam int AW = 24;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  mode;
   logic [3:0]  mask;
   logic        fill;
   logic [15:0] seed;

   logic          ren_a, ren_b, rval_a, rval_b, wval_a, wval_b;
   logic          busy_a, busy_b, fin_a, fin_b;
   logic [AW-1:0] raddr_a, raddr_b, waddr_a, waddr_b;
   logic [3:0]    wen_a, wen_b;
   logic [1:0]    st_a, st_b;

   logic [AW-1:0] pa;
   logic [AW-1:0] pb [0:2];

   int n_assert = 0;
   int n_fail   = 0;
   int wcount [2];

   logic [1:0]  cur_mode;
   logic [3:0]  cur_mask;
   logic        cur_fill;
   logic [15:0] cur_seed;

   always #5 clk = ~clk;

   // Source RAM contents: cell i holds i[0]; latency modelled as an address shift register.
   always @(posedge clk) begin
      pa    <= raddr_a;
      pb[0] <= raddr_b;
      pb[1] <= pb[0];
      pb[2] <= pb[1];
   end
   assign rval_a = pa[0];
   assign rval_b = pb[2][0];

   grid_copier #(.READ_LATENCY(1)) dut_a (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode), .i_dst_mask(mask),
      .i_fill_val(fill), .i_seed(seed), .o_read_en(ren_a), .o_read_addr(raddr_a),
      .i_read_val(rval_a), .o_write_en(wen_a), .o_write_addr(waddr_a), .o_write_val(wval_a),
      .o_busy(busy_a), .o_finish(fin_a), .o_dbg_state(st_a)
   );

   grid_copier #(.READ_LATENCY(3)) dut_b (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode), .i_dst_mask(mask),
      .i_fill_val(fill), .i_seed(seed), .o_read_en(ren_b), .o_read_addr(raddr_b),
      .i_read_val(rval_b), .o_write_en(wen_b), .o_write_addr(waddr_b), .o_write_val(wval_b),
      .o_busy(busy_b), .o_finish(fin_b), .o_dbg_state(st_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [15:0] model_step(input logic [15:0] s);
      logic fb;
      fb = s[0];
      s  = s >> 1;
      if (fb) s = s ^ 16'hB400;
      return s;
   endfunction

   function automatic logic exp_cell(input int k);
      logic [15:0] s;
      case (cur_mode)
         2'd0: return k[0];
         2'd1: return cur_fill;
         2'd2: return 1'b0;
         default: begin
`ifdef GRID_COPIER_LFSR_EN
            s = (cur_seed == 16'd0) ? 16'hACE1 : cur_seed;
            for (int j = 0; j < k; j++) s = model_step(s);
            return s[0];
`else
            s = cur_seed;
            return 1'b0;
`endif
         end
      endcase
   endfunction

   // Expected behaviour of one instance at r cycles after the start edge.
   task automatic check_dut(input int id, input int lat, input int r, input logic ren,
                            input logic [AW-1:0] raddr, input logic [3:0] wen,
                            input logic [AW-1:0] waddr, input logic wval,
                            input logic busy, input logic fin);
      int k;
      chk($sformatf("busy%0d_r%0d", id, r), 32'(busy), 32'((r >= 1) && (r <= NC + lat + 1)));
      chk($sformatf("finish%0d_r%0d", id, r), 32'(fin), 32'(r >= NC + lat + 2));
      chk($sformatf("read_en%0d_r%0d", id, r), 32'(ren), 32'((r >= 1) && (r <= NC)));
      if (r >= 1 && r <= NC) chk($sformatf("read_addr%0d_r%0d", id, r), 32'(raddr), 32'(r - 1));
      k = r - 2 - lat;
      if (k >= 0 && k < NC) begin
         chk($sformatf("write_en%0d_r%0d", id, r), 32'(wen), 32'(cur_mask));
         chk($sformatf("write_addr%0d_r%0d", id, r), 32'(waddr), 32'(k));
         chk($sformatf("write_val%0d_r%0d", id, r), 32'(wval), 32'(exp_cell(k)));
      end else begin
         chk($sformatf("write_idle%0d_r%0d", id, r), 32'(wen), 32'd0);
      end
      if (wen != 4'd0) wcount[id]++;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_ren_a"},   32'(ren_a),   32'd0);
      chk({tag, "_raddr_a"}, 32'(raddr_a), 32'd0);
      chk({tag, "_wen_a"},   32'(wen_a),   32'd0);
      chk({tag, "_waddr_a"}, 32'(waddr_a), 32'd0);
      chk({tag, "_wval_a"},  32'(wval_a),  32'd0);
      chk({tag, "_busy_a"},  32'(busy_a),  32'd0);
      chk({tag, "_fin_a"},   32'(fin_a),   32'd0);
      chk({tag, "_state_a"}, 32'(st_a),    32'd0);
      chk({tag, "_wen_b"},   32'(wen_b),   32'd0);
      chk({tag, "_waddr_b"}, 32'(waddr_b), 32'd0);
      chk({tag, "_busy_b"},  32'(busy_b),  32'd0);
      chk({tag, "_fin_b"},   32'(fin_b),   32'd0);
      chk({tag, "_state_b"}, 32'(st_b),    32'd0);
   endtask

   // restart_at: cycle whose edge sees a second start; abort_at: cycle during which rst is raised.
   task automatic run_sweep(input logic [1:0] m, input logic [3:0] msk, input logic f,
                            input logic [15:0] sd, input int restart_at, input int abort_at);
      cur_mode = m; cur_mask = msk; cur_fill = f; cur_seed = sd;
      wcount[0] = 0; wcount[1] = 0;
      @(negedge clk);
      mode = m; mask = msk; fill = f; seed = sd; start = 1'b1;
      for (int r = 1; r <= 31; r++) begin
         @(negedge clk);
         start = 1'b0;
         if (abort_at > 0 && r == abort_at + 1) begin
            check_zero("after_rst");
            rst = 1'b0;
            return;
         end
         check_dut(0, 1, r, ren_a, raddr_a, wen_a, waddr_a, wval_a, busy_a, fin_a);
         check_dut(1, 3, r, ren_b, raddr_b, wen_b, waddr_b, wval_b, busy_b, fin_b);
         if (r == restart_at - 1) begin
            start = 1'b1; mode = 2'd1; mask = ~msk; fill = ~f; seed = ~sd;
         end
         if (abort_at > 0 && r == abort_at) rst = 1'b1;
      end
      chk("wcount_a", 32'(wcount[0]), (msk != 4'd0) ? 32'(NC) : 32'd0);
      chk("wcount_b", 32'(wcount[1]), (msk != 4'd0) ? 32'(NC) : 32'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; mode = 2'd0; mask = 4'd0; fill = 1'b0; seed = 16'd0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      // start coincident with rst must not launch a sweep
      start = 1'b1;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      check_zero("start_in_rst");

      run_sweep(2'd0, 4'b1111, 1'b0, 16'h0000, 0, 0);   // COPY
      run_sweep(2'd1, 4'b0101, 1'b1, 16'h0000, 0, 0);   // FILL 1
      run_sweep(2'd0, 4'b1111, 1'b0, 16'h0000, 10, 0);  // COPY, stray start at cycle 10
      run_sweep(2'd2, 4'b1010, 1'b1, 16'h0000, 0, 0);   // CLEAR ignores fill_val
      run_sweep(2'd0, 4'b0000, 1'b0, 16'h0000, 0, 0);   // empty mask still finishes
      run_sweep(2'd3, 4'b0011, 1'b1, 16'h0000, 0, 0);   // RANDOM, seed 0
      run_sweep(2'd3, 4'b1100, 1'b0, 16'h1234, 0, 0);   // RANDOM, explicit seed
      run_sweep(2'd0, 4'b1111, 1'b0, 16'h0000, 0, 12);  // rst mid-sweep
      run_sweep(2'd1, 4'b0110, 1'b1, 16'h0000, 0, 0);   // full sweep after reset

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/grid_copier.md
# grid_copier

Parametrised grid copy/fill engine that moves an M×N cell grid from a source RAM into up to NUM_DST destination RAMs, one cell per clock. It sits between the initialisation RAM and the generation buffers and supersedes the four-cycle-per-cell copier. It adds pipelined streaming, multi-bit cells, a per-destination write mask, and fill/clear modes.

## Interface
- P_PARAM_M, 5, grid rows
- P_PARAM_N, 5, grid columns
- WIDTH, 12, half address width; addresses are 2*WIDTH bits
- CELL_BITS, 1, bits per cell
- NUM_DST, 4, destination RAM count
- READ_LATENCY, 1, source RAM read latency in cycles (≥1)
- clk  in  1  sole clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request pulse
- mode  in  2  0 COPY, 1 FILL, 2 CLEAR, 3 RANDOM
- dst_mask  in  NUM_DST  destinations to write
- fill_val  in  CELL_BITS  value for FILL
- seed  in  16  LFSR seed for RANDOM
- read_en  out  1  source read strobe
- read_addr  out  2*WIDTH  source address
- read_val  in  CELL_BITS  source data, valid READ_LATENCY cycles after read_en
- write_en  out  NUM_DST  per-destination write enable
- write_addr  out  2*WIDTH  destination address (shared)
- write_val  out  CELL_BITS  destination data (shared)
- busy  out  1  sweep in progress
- finish  out  1  last sweep complete; level

## Operation
- NCELLS = P_PARAM_M*P_PARAM_N; addresses run 0..NCELLS-1, linear, no wrap.
- States: IDLE → ISSUE (one address per cycle) → DRAIN (READ_LATENCY+1 cycles of in-flight writes) → IDLE.
- IDLE + start: latch mode, dst_mask, fill_val and seed; clear finish; go to ISSUE with address 0. Inputs are not re-sampled mid-sweep.
- start while busy is ignored. start coincident with rst is ignored.
- ISSUE: read_en=1 and read_addr=k for every mode, so the pipeline is uniform. After k=NCELLS-1 go to DRAIN.
- Write data for address k: COPY gives read_val; FILL gives latched fill_val; CLEAR gives 0; RANDOM gives the low CELL_BITS bits of the LFSR, which advances once per cell.
- write_en = latched dst_mask during each write cycle, else 0. A dst_mask of 0 still sweeps and sets finish.
- Leaving DRAIN: busy goes 0 and finish goes 1. finish holds until the next accepted start or rst.
- rst at any time: state IDLE, in-flight writes dropped, all outputs return to reset values.
- Reset values: read_en 0, read_addr 0, write_en 0, write_addr 0, write_val 0, busy 0, finish 0.

## Timing
- start sampled high at cycle t. From t+1, busy=1 and read_addr=0 with read_en=1.
- Address k is issued at t+1+k, and read_val is sampled at t+1+k+READ_LATENCY.
- write_* are registered and valid at t+2+k+READ_LATENCY.
- The last write is at t+NCELLS+READ_LATENCY+1. finish=1 and busy=0 at t+NCELLS+READ_LATENCY+2.
- Sustained throughput is 1 cell/cycle. No bubbles.

## Configuration
- GRID_COPIER_LFSR_EN defined: RANDOM mode uses a 16-bit Galois LFSR with mask 0xB400. It is loaded from seed on start; seed 0 is replaced by 0xACE1.
- GRID_COPIER_LFSR_EN undefined: no LFSR is built, the seed port is ignored, and mode 3 behaves exactly as CLEAR.

## Structure
- Package grid_pkg holds the mode enum (MODE_COPY, MODE_FILL, MODE_CLEAR, MODE_RANDOM), the state enum (ST_IDLE, ST_ISSUE, ST_DRAIN) and the LFSR constants (0xB400, 0xACE1).
- Sub-module grid_lfsr holds the seedable 16-bit LFSR with load/step inputs. It is instantiated only under GRID_COPIER_LFSR_EN.
- The address/valid delay line (READ_LATENCY+1 stages) stays inline.

## Test plan
- M=N=5, L=1, COPY, mask 4'b1111, source[i]=i[0]; start at t=0 → 25 writes at cycles 3..27 with write_val=i[0] and write_en=4'b1111; finish=1 at cycle 28.
- FILL, fill_val=1, mask 4'b0101 → every write has write_en=4'b0101 and write_val=1; busy is high cycles 1..27.
- Second start pulse at cycle 10 during a sweep → ignored; the write count stays 25 and timing is unchanged.
- READ_LATENCY=3, COPY → first write at cycle 5, last at 29, finish at 30; the data/address pairing is correct.
- rst asserted at cycle 12 mid-sweep → from cycle 13 all outputs are 0 and the state is IDLE; a new start then completes a full 25-cell sweep.
- With the macro defined: RANDOM, seed 0 → the cell sequence matches an LFSR seeded 0xACE1. Without the macro: mode 3 writes all zeros.
